// File: rtl/reg_file_dump_if.sv
// -----------------------------------------------------------------------------
// reg_file_dump_if
// Beat interface carrying register-file dump data from reg_file_dump to the
// debug/trace consumer. Valid/ready handshake; a beat transfers on a rising
// clock edge where DUMP_VALID and DUMP_READY are both high.
//
// Signals:
//   DUMP_DATA  [DATA_W] beat data (register value, or checksum on trailer)
//   DUMP_ADDR  [ADDR_W] register index of the beat
//   DUMP_LAST           final beat of the dump
//   DUMP_VALID          beat valid
//   DUMP_READY          consumer ready
//   DUMP_CSUM           trailer beat marker (only with REG_FILE_DUMP_CSUM_EN)
//
// Modports: master = dump engine, slave = consumer.
// Optional feature macro: REG_FILE_DUMP_CSUM_EN
// -----------------------------------------------------------------------------
interface reg_file_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] DUMP_DATA;
  logic [ADDR_W-1:0] DUMP_ADDR;
  logic              DUMP_LAST;
  logic              DUMP_VALID;
  logic              DUMP_READY;
`ifdef REG_FILE_DUMP_CSUM_EN
  logic              DUMP_CSUM;
`endif

  modport master (
`ifdef REG_FILE_DUMP_CSUM_EN
    output DUMP_CSUM,
`endif
    output DUMP_DATA,
    output DUMP_ADDR,
    output DUMP_LAST,
    output DUMP_VALID,
    input  DUMP_READY
  );

  modport slave (
`ifdef REG_FILE_DUMP_CSUM_EN
    input  DUMP_CSUM,
`endif
    input  DUMP_DATA,
    input  DUMP_ADDR,
    input  DUMP_LAST,
    input  DUMP_VALID,
    output DUMP_READY
  );
endinterface

// File: rtl/reg_file_dump.sv
// -----------------------------------------------------------------------------
// reg_file_dump
// Debug read-out engine for the RISC-V integer register file. Owns the
// REG_FILE A read port (ADD_A out, REG_A in; the file reads combinationally)
// and streams the inclusive range FIRST_ADD..LAST_ADD out as one beat per
// register over the dump beat interface.
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   START      dump request, sampled only while idle
//   FIRST_ADD  first register of range, latched on accepted START
//   LAST_ADD   last register of range (inclusive), latched on accepted START
//   ABORT      cancel a dump in progress (ignored while idle)
//   ADD_A      REG_FILE read address, the registered read pointer
//   REG_A      REG_FILE read data
//   BUSY       high whenever the engine is not idle
//   DONE       one-cycle pulse on normal completion (also for an empty range)
//   dump       beat interface (master side)
//
// Optional feature macro: REG_FILE_DUMP_CSUM_EN
//   When defined, an XOR checksum of all register beats is appended as a
//   trailer beat (DUMP_ADDR=0, DUMP_CSUM=1, DUMP_LAST=1); the register beat
//   for the last register then carries DUMP_LAST=0.
// -----------------------------------------------------------------------------
module reg_file_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] FIRST_ADD,
  input  logic [ADDR_W-1:0] LAST_ADD,
  input  logic              ABORT,
  output logic [ADDR_W-1:0] ADD_A,
  input  logic [DATA_W-1:0] REG_A,
  output logic              BUSY,
  output logic              DONE,
  reg_file_dump_if.master   dump
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q,   ptr_d;
  logic [ADDR_W-1:0] end_q,   end_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              last_q,  last_d;
  logic              valid_q, valid_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              hs;

`ifdef REG_FILE_DUMP_CSUM_EN
  logic [DATA_W-1:0] acc_q,     acc_d;
  logic              csum_q,    csum_d;
  // Marks the register beat for END, which is followed by the trailer
  // instead of terminating the dump.
  logic              end_beat_q, end_beat_d;
`endif

  assign hs = valid_q & dump.DUMP_READY;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    data_d  = data_q;
    addr_d  = addr_q;
    last_d  = last_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef REG_FILE_DUMP_CSUM_EN
    acc_d      = acc_q;
    csum_d     = csum_q;
    end_beat_d = end_beat_q;
`endif

    case (state_q)
      IDLE: begin
        if (START) begin
          if (FIRST_ADD <= LAST_ADD) begin
            ptr_d   = FIRST_ADD;
            end_d   = LAST_ADD;
            state_d = READ;
`ifdef REG_FILE_DUMP_CSUM_EN
            acc_d   = '0;
`endif
          end else begin
            // Empty range: nothing to send, just acknowledge.
            done_d = 1'b1;
          end
        end
      end

      READ: begin
        if (ABORT) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ptr_d   = '0;
        end else begin
          // REG_A already reflects ADD_A (=ptr_q); capture it here so later
          // writes to the same register do not leak into this beat.
          data_d  = REG_A;
          addr_d  = ptr_q;
          valid_d = 1'b1;
          state_d = SEND;
`ifdef REG_FILE_DUMP_CSUM_EN
          last_d     = 1'b0;
          csum_d     = 1'b0;
          end_beat_d = (ptr_q == end_q);
`else
          last_d  = (ptr_q == end_q);
`endif
        end
      end

      SEND: begin
        if (ABORT) begin
          // A handshake in this same cycle still counts as delivered; the
          // consumer sees it, the engine simply stops afterwards.
          state_d = IDLE;
          valid_d = 1'b0;
          ptr_d   = '0;
`ifdef REG_FILE_DUMP_CSUM_EN
          csum_d     = 1'b0;
          end_beat_d = 1'b0;
`endif
        end else if (hs) begin
          if (last_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
            ptr_d   = '0;
`ifdef REG_FILE_DUMP_CSUM_EN
            csum_d  = 1'b0;
`endif
          end
`ifdef REG_FILE_DUMP_CSUM_EN
          else if (end_beat_q) begin
            // Trailer is loaded straight from the end-register handshake;
            // VALID stays high and the state stays SEND.
            acc_d      = acc_q ^ data_q;
            data_d     = acc_q ^ data_q;
            addr_d     = '0;
            last_d     = 1'b1;
            csum_d     = 1'b1;
            end_beat_d = 1'b0;
          end
`endif
          else begin
            valid_d = 1'b0;
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = READ;
`ifdef REG_FILE_DUMP_CSUM_EN
            acc_d   = acc_q ^ data_q;
`endif
          end
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ptr_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REG_FILE_DUMP_CSUM_EN
      acc_q      <= '0;
      csum_q     <= 1'b0;
      end_beat_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef REG_FILE_DUMP_CSUM_EN
      acc_q      <= acc_d;
      csum_q     <= csum_d;
      end_beat_q <= end_beat_d;
`endif
    end
  end

  assign ADD_A           = ptr_q;
  assign BUSY            = busy_q;
  assign DONE            = done_q;
  assign dump.DUMP_DATA  = data_q;
  assign dump.DUMP_ADDR  = addr_q;
  assign dump.DUMP_LAST  = last_q;
  assign dump.DUMP_VALID = valid_q;
`ifdef REG_FILE_DUMP_CSUM_EN
  assign dump.DUMP_CSUM  = csum_q;
`endif

endmodule

// File: tb/tb_reg_file_dump.sv
// -----------------------------------------------------------------------------
// tb_reg_file_dump
// Self-checking bench for reg_file_dump. A behavioural register file feeds
// REG_A; every dump request is turned into a queue of expected beats computed
// directly from the requested range and the register contents. A monitor
// pops and compares beats on each handshake and checks that a stalled beat
// holds steady. Honours REG_FILE_DUMP_CSUM_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_file_dump;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          last;
    logic          cs;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] first_add = '0;
  logic [AW-1:0] last_add = '0;
  logic [AW-1:0] add_a;
  logic [DW-1:0] reg_a;
  logic          busy;
  logic          done;
  logic [DW-1:0] rf [32];

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    done_cnt = 0;
  int    ready_mode = 0;   // 0 low, 1 high, 2 random
  logic  busy_seen = 1'b0;

  reg_file_dump_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();

  reg_file_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start),
    .FIRST_ADD (first_add),
    .LAST_ADD  (last_add),
    .ABORT     (abort),
    .ADD_A     (add_a),
    .REG_A     (reg_a),
    .BUSY      (busy),
    .DONE      (done),
    .dump      (dif)
  );

  assign reg_a = rf[add_a];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // READY driver
  initial begin
    dif.DUMP_READY = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       dif.DUMP_READY = 1'b0;
        1:       dif.DUMP_READY = 1'b1;
        default: dif.DUMP_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Beat monitor: samples at the falling edge, where inputs and outputs are
  // settled; a handshake seen here completes on the next rising edge.
  initial begin
    logic          pv, pr, pl, pc, pd;
    logic [AW-1:0] pa;
    logic [DW-1:0] pdat;
    beat_t         b;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pc = 1'b0; pd = 1'b0; pa = '0; pdat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0; pd = 1'b0;
      end else begin
        if (busy) busy_seen = 1'b1;
        if (done) begin
          check("done_single_cycle", pd, 0);
          done_cnt++;
        end
        if (pv && !pr) begin
          check("hold_valid", dif.DUMP_VALID, 1);
          check("hold_data", dif.DUMP_DATA, pdat);
          check("hold_addr", dif.DUMP_ADDR, pa);
          check("hold_last", dif.DUMP_LAST, pl);
`ifdef REG_FILE_DUMP_CSUM_EN
          check("hold_csum", dif.DUMP_CSUM, pc);
`endif
        end
        if (dif.DUMP_VALID && dif.DUMP_READY) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check("beat_addr", dif.DUMP_ADDR, b.a);
            check("beat_data", dif.DUMP_DATA, b.d);
            check("beat_last", dif.DUMP_LAST, b.last);
`ifdef REG_FILE_DUMP_CSUM_EN
            check("beat_csum", dif.DUMP_CSUM, b.cs);
`endif
          end
        end
        pv = dif.DUMP_VALID; pr = dif.DUMP_READY; pl = dif.DUMP_LAST;
        pa = dif.DUMP_ADDR; pdat = dif.DUMP_DATA; pd = done;
`ifdef REG_FILE_DUMP_CSUM_EN
        pc = dif.DUMP_CSUM;
`else
        pc = 1'b0;
`endif
      end
    end
  end

  // Expected beats for a complete dump of f..l (nothing for an empty range).
  task automatic push_range(input int unsigned f, input int unsigned l);
    beat_t         b;
    logic [DW-1:0] acc;
    acc = '0;
    if (f <= l) begin
      for (int unsigned a = f; a <= l; a++) begin
        b.a = AW'(a);
        b.d = rf[a];
        b.cs = 1'b0;
`ifdef REG_FILE_DUMP_CSUM_EN
        b.last = 1'b0;
`else
        b.last = (a == l);
`endif
        acc ^= rf[a];
        exp_q.push_back(b);
      end
`ifdef REG_FILE_DUMP_CSUM_EN
      b.a = '0; b.d = acc; b.last = 1'b1; b.cs = 1'b1;
      exp_q.push_back(b);
`endif
    end
  endtask

  task automatic pulse_start(input int unsigned f, input int unsigned l);
    @(posedge clk); #1;
    start = 1'b1; first_add = AW'(f); last_add = AW'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic await_idle(input int base_done, input int exp_done);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_in_time", (exp_q.size() != 0) || busy, 0);
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    check("done_count", done_cnt - base_done, exp_done);
    check("busy_after", busy, 0);
    check("valid_after", dif.DUMP_VALID, 0);
    check("add_a_after", add_a, 0);
  endtask

  task automatic run_dump(input int unsigned f, input int unsigned l, input int mode);
    int base;
    ready_mode = mode;
    base = done_cnt;
    push_range(f, l);
    pulse_start(f, l);
    await_idle(base, 1);
  endtask

  task automatic wait_beat_addr(input int unsigned a, output logic found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (dif.DUMP_VALID && dif.DUMP_ADDR == AW'(a)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int    base;
    logic  found;
    beat_t b;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = '0;

    // Reset state
    #12;
    check("rst_add_a", add_a, 0);
    check("rst_valid", dif.DUMP_VALID, 0);
    check("rst_data", dif.DUMP_DATA, 0);
    check("rst_addr", dif.DUMP_ADDR, 0);
    check("rst_last", dif.DUMP_LAST, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef REG_FILE_DUMP_CSUM_EN
    check("rst_csum", dif.DUMP_CSUM, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-dump, during the second beat
    rf[1] = 32'd1; rf[2] = 32'd2; rf[3] = 32'd3;
    ready_mode = 1;
    b.a = 5'd1; b.d = 32'd1; b.last = 1'b0; b.cs = 1'b0;
    exp_q.push_back(b);
    pulse_start(1, 3);
    wait_beat_addr(2, found);
    check("mid_rst_reached_beat2", found, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_add_a", add_a, 0);
    check("mid_rst_valid", dif.DUMP_VALID, 0);
    check("mid_rst_data", dif.DUMP_DATA, 0);
    check("mid_rst_addr", dif.DUMP_ADDR, 0);
    check("mid_rst_last", dif.DUMP_LAST, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_beat1_seen", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", busy, 0);
    run_dump(1, 3, 1);

    // Basic dump
    rf[1] = 32'h01; rf[2] = 32'h02;
    run_dump(1, 2, 1);

    // Backpressure on a single-register dump; rf[5] changes after capture
    rf[5] = 32'hDEADBEEF;
    ready_mode = 0;
    base = done_cnt;
    push_range(5, 5);
    pulse_start(5, 5);
    wait_beat_addr(5, found);
    check("bp_valid_seen", found, 1);
    rf[5] = 32'h12345678;
    repeat (4) begin @(posedge clk); #1; end
    check("bp_valid_held", dif.DUMP_VALID, 1);
    check("bp_data_held", dif.DUMP_DATA, 32'hDEADBEEF);
    check("bp_addr_held", dif.DUMP_ADDR, 5);
    ready_mode = 1;
    await_idle(base, 1);

    // Full range, random backpressure
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    run_dump(0, 31, 2);

    // Empty range
    busy_seen = 1'b0;
    run_dump(4, 3, 2);
    check("empty_never_busy", busy_seen, 0);

    // Abort together with the handshake of beat 2
    ready_mode = 1;
    base = done_cnt;
    for (int unsigned a = 0; a <= 2; a++) begin
      b.a = AW'(a); b.d = rf[a]; b.last = 1'b0; b.cs = 1'b0;
      exp_q.push_back(b);
    end
    pulse_start(0, 7);
    wait_beat_addr(2, found);
    check("abort_reached_beat2", found, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    await_idle(base, 0);

    // START while busy is ignored
    ready_mode = 2;
    base = done_cnt;
    push_range(8, 10);
    pulse_start(8, 10);
    check("busy_after_start", busy, 1);
    start = 1'b1; first_add = 5'd20; last_add = 5'd25;
    @(posedge clk); #1;
    start = 1'b0;
    await_idle(base, 1);

`ifdef REG_FILE_DUMP_CSUM_EN
    // Checksum trailer
    rf[1] = 32'hF0F0F0F0; rf[2] = 32'h0F0F00FF;
    run_dump(1, 2, 1);
`endif

    // Random ranges and contents
    for (int t = 0; t < 8; t++) begin
      int unsigned f, l;
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      f = $urandom_range(0, 31);
      l = $urandom_range(0, 31);
      run_dump(f, l, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
